// File: rtl/pc_sequencer.sv
// Program-counter stage fed by SignExtender. It generates sequential fetch addresses,
// applies resolved branch targets, and holds a taken target while instruction memory stalls.
module pc_sequencer #(
    parameter int PC_WIDTH    = 64,
    parameter int INSTR_BYTES = 4
) (
    input  logic                CLK,
    input  logic                resetl,
    input  logic [PC_WIDTH-1:0] startPC,
    input  logic                fetch_ready,
    input  logic                br_valid,
    input  logic                Branch,
    input  logic                Uncondbranch,
    input  logic                Zero,
    input  logic [PC_WIDTH-1:0] issue_pc,
    input  logic [PC_WIDTH-1:0] SignExOut,
    output logic [PC_WIDTH-1:0] PC,
    output logic                fetch_req,
    output logic                redirect
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] INCR = PC_WIDTH'(INSTR_BYTES);

    state_t              state;
    state_t              next_state;
    logic [PC_WIDTH-1:0] pend_pc;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] pend_next;
    logic                redirect_next;
    logic                take;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] seq;

    // Unconditional wins whenever both branch controls are set.
    assign take   = br_valid & (Uncondbranch | (Branch & Zero));
    assign target = issue_pc + SignExOut;
    assign seq    = PC + INCR;

    always_ff @(posedge CLK) begin
        if (!resetl) begin
            state    <= IDLE;
            PC       <= startPC;
            pend_pc  <= '0;
            redirect <= 1'b0;
        end else begin
            state    <= next_state;
            PC       <= pc_next;
            pend_pc  <= pend_next;
            redirect <= redirect_next;
        end
    end

    always_comb begin
        next_state    = state;
        pc_next       = PC;
        pend_next     = pend_pc;
        redirect_next = 1'b0;
        case (state)
            IDLE: begin
                next_state = RUN;
            end
            RUN: begin
                if (fetch_ready) begin
                    if (take) begin
                        pc_next       = target;
                        redirect_next = 1'b1;
                    end else begin
                        pc_next = seq;
                    end
                end else if (take) begin
                    pend_next  = target;
                    next_state = PEND;
                end
            end
            // Branch info arriving here belongs to a wrong-path instruction.
            PEND: begin
                if (fetch_ready) begin
                    pc_next       = pend_pc;
                    redirect_next = 1'b1;
                    next_state    = RUN;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        fetch_req = 1'b0;
        case (state)
            RUN, PEND: fetch_req = 1'b1;
            default:   fetch_req = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each step pushes the expected post-edge PC,
// fetch_req and redirect, and the step's result is popped and compared after the edge.
module tb_pc_sequencer;

    typedef struct {
        logic        rstn;
        logic        fr;
        logic        bv;
        logic        br;
        logic        ub;
        logic        z;
        logic [63:0] ipc;
        logic [63:0] off;
        logic [63:0] epc;
        logic        ereq;
        logic        ered;
    } step_t;

    typedef struct {
        logic [63:0] pc;
        logic        req;
        logic        red;
    } exp_t;

    localparam logic [63:0] START = 64'h1000;

    logic        CLK = 1'b0;
    logic        resetl;
    logic [63:0] startPC;
    logic        fetch_ready;
    logic        br_valid;
    logic        Branch;
    logic        Uncondbranch;
    logic        Zero;
    logic [63:0] issue_pc;
    logic [63:0] SignExOut;
    logic [63:0] PC;
    logic        fetch_req;
    logic        redirect;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    pc_sequencer #(.PC_WIDTH(64), .INSTR_BYTES(4)) dut (
        .CLK(CLK),
        .resetl(resetl),
        .startPC(startPC),
        .fetch_ready(fetch_ready),
        .br_valid(br_valid),
        .Branch(Branch),
        .Uncondbranch(Uncondbranch),
        .Zero(Zero),
        .issue_pc(issue_pc),
        .SignExOut(SignExOut),
        .PC(PC),
        .fetch_req(fetch_req),
        .redirect(redirect)
    );

    always #5 CLK = ~CLK;

    function automatic step_t mk(input logic rstn, input logic fr, input logic bv,
                                 input logic br, input logic ub, input logic z,
                                 input logic [63:0] ipc, input logic [63:0] off,
                                 input logic [63:0] epc, input logic ereq, input logic ered);
        step_t s;
        s.rstn = rstn; s.fr = fr; s.bv = bv; s.br = br; s.ub = ub; s.z = z;
        s.ipc = ipc; s.off = off; s.epc = epc; s.ereq = ereq; s.ered = ered;
        return s;
    endfunction

    // Drive one cycle of inputs, record its expectation, and land #1 past the edge.
    task automatic drive_step(input step_t s);
        exp_t e;
        resetl       = s.rstn;
        fetch_ready  = s.fr;
        br_valid     = s.bv;
        Branch       = s.br;
        Uncondbranch = s.ub;
        Zero         = s.z;
        issue_pc     = s.ipc;
        SignExOut    = s.off;
        e.pc  = s.epc;
        e.req = s.ereq;
        e.red = s.ered;
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(0, 1, 1, 1, 1, 1, 64'h5000, 64'h10, START, 0, 0));
        s.push_back(mk(0, 1, 1, 0, 1, 0, 64'h6000, 64'h20, START, 0, 0));
        foreach (s[i]) begin
            drive_step(s[i]);
            e = sb.pop_front();
            checks++;
            if ({PC, fetch_req, redirect} !== {e.pc, e.req, e.red}) begin
                errors++;
                $display("[TB] FAIL test_reset[%0d] pc=%h req=%b red=%b expected pc=%h req=%b red=%b",
                         i, PC, fetch_req, redirect, e.pc, e.req, e.red);
            end
        end
    endtask

    task automatic test_sequential();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1, 1, 1, 0, 1, 0, 64'h5000, 64'h40, START, 1, 0));
        s.push_back(mk(1, 1, 0, 0, 0, 0, 64'h0, 64'h0, 64'h1004, 1, 0));
        s.push_back(mk(1, 1, 0, 0, 0, 0, 64'h0, 64'h0, 64'h1008, 1, 0));
        s.push_back(mk(1, 1, 0, 0, 0, 0, 64'h0, 64'h0, 64'h100C, 1, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h100C, 1, 0));
        s.push_back(mk(1, 0, 1, 1, 0, 0, 64'h100C, 64'h80, 64'h100C, 1, 0));
        foreach (s[i]) begin
            drive_step(s[i]);
            e = sb.pop_front();
            checks++;
            if ({PC, fetch_req, redirect} !== {e.pc, e.req, e.red}) begin
                errors++;
                $display("[TB] FAIL test_sequential[%0d] pc=%h req=%b red=%b expected pc=%h req=%b red=%b",
                         i, PC, fetch_req, redirect, e.pc, e.req, e.red);
            end
        end
    endtask

    task automatic test_btype_taken();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1, 1, 1, 0, 1, 0, 64'h1008, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0FF8, 1, 1));
        s.push_back(mk(1, 1, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0FFC, 1, 0));
        s.push_back(mk(1, 1, 0, 0, 1, 1, 64'h0FFC, 64'h100, 64'h1000, 1, 0));
        foreach (s[i]) begin
            drive_step(s[i]);
            e = sb.pop_front();
            checks++;
            if ({PC, fetch_req, redirect} !== {e.pc, e.req, e.red}) begin
                errors++;
                $display("[TB] FAIL test_btype_taken[%0d] pc=%h req=%b red=%b expected pc=%h req=%b red=%b",
                         i, PC, fetch_req, redirect, e.pc, e.req, e.red);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1, 1, 1, 0, 1, 0, 64'h3000, 64'h10, 64'h3010, 1, 1));
        s.push_back(mk(1, 1, 1, 1, 1, 0, 64'h3010, 64'h20, 64'h3030, 1, 1));
        s.push_back(mk(1, 1, 0, 0, 0, 0, 64'h0, 64'h0, 64'h3034, 1, 0));
        foreach (s[i]) begin
            drive_step(s[i]);
            e = sb.pop_front();
            checks++;
            if ({PC, fetch_req, redirect} !== {e.pc, e.req, e.red}) begin
                errors++;
                $display("[TB] FAIL test_back_to_back[%0d] pc=%h req=%b red=%b expected pc=%h req=%b red=%b",
                         i, PC, fetch_req, redirect, e.pc, e.req, e.red);
            end
        end
    endtask

    task automatic test_cbz();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1, 1, 1, 0, 1, 0, 64'h1F00, 64'h100, 64'h2000, 1, 1));
        s.push_back(mk(1, 1, 1, 1, 0, 0, 64'h2000, 64'h40, 64'h2004, 1, 0));
        s.push_back(mk(1, 1, 1, 1, 0, 1, 64'h2004, 64'h8, 64'h200C, 1, 1));
        s.push_back(mk(1, 1, 0, 1, 1, 1, 64'h200C, 64'h80, 64'h2010, 1, 0));
        foreach (s[i]) begin
            drive_step(s[i]);
            e = sb.pop_front();
            checks++;
            if ({PC, fetch_req, redirect} !== {e.pc, e.req, e.red}) begin
                errors++;
                $display("[TB] FAIL test_cbz[%0d] pc=%h req=%b red=%b expected pc=%h req=%b red=%b",
                         i, PC, fetch_req, redirect, e.pc, e.req, e.red);
            end
        end
    endtask

    task automatic test_stalled_branch();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1, 1, 1, 0, 1, 0, 64'h1FF0, 64'h10, 64'h2000, 1, 1));
        s.push_back(mk(1, 0, 1, 1, 0, 1, 64'h2000, 64'h40, 64'h2000, 1, 0));
        s.push_back(mk(1, 0, 1, 0, 1, 0, 64'h2000, 64'h100, 64'h2000, 1, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h2000, 1, 0));
        s.push_back(mk(1, 1, 1, 0, 1, 0, 64'h9000, 64'h4, 64'h2040, 1, 1));
        s.push_back(mk(1, 1, 0, 0, 0, 0, 64'h0, 64'h0, 64'h2044, 1, 0));
        foreach (s[i]) begin
            drive_step(s[i]);
            e = sb.pop_front();
            checks++;
            if ({PC, fetch_req, redirect} !== {e.pc, e.req, e.red}) begin
                errors++;
                $display("[TB] FAIL test_stalled_branch[%0d] pc=%h req=%b red=%b expected pc=%h req=%b red=%b",
                         i, PC, fetch_req, redirect, e.pc, e.req, e.red);
            end
        end
    endtask

    task automatic test_reset_mid_pend();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1, 0, 1, 0, 1, 0, 64'h2000, 64'h40, 64'h2044, 1, 0));
        s.push_back(mk(0, 1, 0, 0, 0, 0, 64'h0, 64'h0, START, 0, 0));
        s.push_back(mk(1, 1, 0, 0, 0, 0, 64'h0, 64'h0, START, 1, 0));
        s.push_back(mk(1, 1, 0, 0, 0, 0, 64'h0, 64'h0, 64'h1004, 1, 0));
        s.push_back(mk(1, 1, 0, 0, 0, 0, 64'h0, 64'h0, 64'h1008, 1, 0));
        foreach (s[i]) begin
            drive_step(s[i]);
            e = sb.pop_front();
            checks++;
            if ({PC, fetch_req, redirect} !== {e.pc, e.req, e.red}) begin
                errors++;
                $display("[TB] FAIL test_reset_mid_pend[%0d] pc=%h req=%b red=%b expected pc=%h req=%b red=%b",
                         i, PC, fetch_req, redirect, e.pc, e.req, e.red);
            end
        end
    endtask

    task automatic test_wrap();
        step_t s[$];
        exp_t  e;
        s.push_back(mk(1, 1, 1, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 64'h4, 1, 1));
        s.push_back(mk(1, 1, 1, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'hC, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1));
        s.push_back(mk(1, 1, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 1, 0));
        s.push_back(mk(1, 1, 1, 1, 0, 1, 64'h1001, 64'h2, 64'h1003, 1, 1));
        s.push_back(mk(1, 1, 0, 0, 0, 0, 64'h0, 64'h0, 64'h1007, 1, 0));
        foreach (s[i]) begin
            drive_step(s[i]);
            e = sb.pop_front();
            checks++;
            if ({PC, fetch_req, redirect} !== {e.pc, e.req, e.red}) begin
                errors++;
                $display("[TB] FAIL test_wrap[%0d] pc=%h req=%b red=%b expected pc=%h req=%b red=%b",
                         i, PC, fetch_req, redirect, e.pc, e.req, e.red);
            end
        end
    endtask

    initial begin
        startPC      = START;
        resetl       = 1'b0;
        fetch_ready  = 1'b0;
        br_valid     = 1'b0;
        Branch       = 1'b0;
        Uncondbranch = 1'b0;
        Zero         = 1'b0;
        issue_pc     = '0;
        SignExOut    = '0;
        #2;
        test_reset();
        test_sequential();
        test_btype_taken();
        test_back_to_back();
        test_cbz();
        test_stalled_branch();
        test_reset_mid_pend();
        test_wrap();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain left=%0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage directly downstream of SignExtender.
- Consumes SignExOut as the branch offset for CB-type and B-type instructions (offset already sign-extended and shifted left 2) and computes the next fetch address.
- Drives the instruction-memory fetch address with a valid/ready handshake.
- Holds a pending redirect when a taken branch resolves while a fetch is stalled.
- Emits a one-cycle redirect pulse so upstream stages can squash wrong-path instructions.

Parameters:
- PC_WIDTH, 64, width of PC, startPC, issue_pc, SignExOut and all address arithmetic.
- INSTR_BYTES, 4, sequential PC increment in bytes.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- resetl  input  1  synchronous, active-low reset.
- startPC  input  PC_WIDTH  address loaded into PC during reset.
- fetch_ready  input  1  instruction memory accepts PC this cycle when fetch_req=1.
- br_valid  input  1  branch resolution information is valid this cycle.
- Branch  input  1  conditional branch (CBZ) control.
- Uncondbranch  input  1  unconditional branch (B) control.
- Zero  input  1  ALU zero flag for the resolving instruction.
- issue_pc  input  PC_WIDTH  PC of the resolving instruction.
- SignExOut  input  PC_WIDTH  byte offset from SignExtender.
- PC  output  PC_WIDTH  current fetch address.
- fetch_req  output  1  fetch address valid.
- redirect  output  1  one-cycle pulse: PC was just loaded with a branch target.

Behaviour:
- Reset (resetl=0 at a rising edge, regardless of state):
  - PC<=startPC, state<=IDLE, fetch_req=0, redirect<=0, pend_pc<=0.
  - Reset overrides all other inputs.
- Definitions:
  - take = br_valid & (Uncondbranch | (Branch & Zero)).
  - target = issue_pc + SignExOut, modulo 2^PC_WIDTH (wrap, no overflow flag).
  - seq = PC + INSTR_BYTES, modulo 2^PC_WIDTH.
- fetch_req is combinational from state: 0 in IDLE, 1 in RUN and PEND.
- Handshake rule: while fetch_req=1 and fetch_ready=0, PC must not change.
- IDLE:
  - Always moves to RUN next cycle.
  - PC holds startPC; br_valid is ignored.
- RUN:
  - take & fetch_ready: PC<=target, redirect<=1, stay RUN.
  - take & !fetch_ready: pend_pc<=target, PC holds, state<=PEND, redirect<=0.
  - !take & fetch_ready: PC<=seq, redirect<=0.
  - !take & !fetch_ready: hold all, redirect<=0.
- PEND:
  - br_valid is ignored; it comes from a wrong-path instruction.
  - fetch_ready=0: hold PC and pend_pc, redirect<=0.
  - fetch_ready=1: PC<=pend_pc, redirect<=1, state<=RUN.
- redirect is registered: it goes high in the cycle in which PC first shows the target, and is never high for two consecutive cycles unless two consecutive taken redirects occur in RUN.
- Latency:
  - Sequential advance: 1 cycle after acceptance.
  - Taken branch with ready: target visible 1 cycle after br_valid.
  - Taken branch while stalled: target visible 1 cycle after the first fetch_ready=1.
- Branch=1 and Uncondbranch=1 together: treated as unconditional (taken).
- Alignment: no alignment check. PC low 2 bits follow the arithmetic exactly.

Test Plan:
- Reset release: startPC=0x1000, resetl 0→1 → first cycle PC=0x1000, fetch_req=0; next cycle fetch_req=1; fetch_ready=1 for 3 cycles → PC=0x1004, 0x1008, 0x100C; redirect stays 0.
- B-type taken: br_valid=1, Uncondbranch=1, issue_pc=0x1008, SignExOut=0xFFFFFFFFFFFFFFF0, fetch_ready=1 → next cycle PC=0x0FF8, redirect=1 for exactly one cycle.
- CBZ not taken: Branch=1, Zero=0, br_valid=1, PC=0x2000, fetch_ready=1 → PC=0x2004, redirect=0.
- Stalled taken branch:
  - Setup: fetch_ready=0, Branch=1, Zero=1, issue_pc=0x2000, SignExOut=0x40.
  - Expect PC held, state PEND.
  - Next cycle: br_valid=1 with Uncondbranch and SignExOut=0x100 → ignored.
  - fetch_ready=1 two cycles later → PC=0x2040 with redirect=1; following cycle PC=0x2044.
- Reset mid-PEND: resetl=0 while pending target 0x2040 → PC=startPC, fetch_req=0, redirect=0; pending target is never applied after release.
- Wrap-around: issue_pc=0xFFFFFFFFFFFFFFFC, SignExOut=0x8, Uncondbranch=1, fetch_ready=1 → PC=0x0000000000000004, redirect=1.
